// File: rtl/gated_event_counter.sv
// Counts synchronized detector pulses while the gate is open and publishes one
// result word per gate window over a valid/ready handshake.
module gated_event_counter #(
  parameter int unsigned COUNT_W = 16,
  parameter int unsigned TOTAL_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_gate,
  input  logic               i_event,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [COUNT_W-1:0] o_count,
  output logic [15:0]        o_window,
  output logic               o_overflow,
  output logic [15:0]        o_drops,
  output logic [TOTAL_W-1:0] o_total,
  output logic               o_busy
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_t             state, state_nxt;
  logic               sync1, sync2, last, gate_d;
  logic [COUNT_W-1:0] cnt, cnt_nxt;
  logic               ovf, ovf_nxt;
  logic [15:0]        win;
  logic               ev, rise, fall;
  logic               count_ev, publish, load;

  assign ev     = sync2 & ~last;
  assign rise   = i_gate & ~gate_d;
  assign fall   = ~i_gate & gate_d;
  assign load   = publish & (~o_valid | i_ready);
  assign o_busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    count_ev  = 1'b0;
    publish   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = COUNT;
          cnt_nxt   = COUNT_W'(ev);
          ovf_nxt   = 1'b0;
          count_ev  = ev;
        end
      end
      COUNT: begin
        if (fall) begin
          state_nxt = DONE;
        end else if (ev && i_gate) begin
          count_ev = 1'b1;
          // Saturate: an event arriving at the ceiling marks the window as overflowed
          if (cnt == CNT_MAX) ovf_nxt = 1'b1;
          else                cnt_nxt = cnt + COUNT_W'(1);
        end
      end
      DONE: begin
        publish = 1'b1;
        if (rise) begin
          state_nxt = COUNT;
          cnt_nxt   = COUNT_W'(ev);
          ovf_nxt   = 1'b0;
          count_ev  = ev;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      last       <= 1'b0;
      gate_d     <= 1'b0;
      cnt        <= '0;
      ovf        <= 1'b0;
      win        <= '0;
      o_valid    <= 1'b0;
      o_count    <= '0;
      o_window   <= '0;
      o_overflow <= 1'b0;
      o_drops    <= '0;
      o_total    <= '0;
    end else begin
      sync1  <= i_event;
      sync2  <= sync1;
      last   <= sync2;
      gate_d <= i_gate;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ovf    <= ovf_nxt;
      if (count_ev) o_total <= o_total + TOTAL_W'(1);
      if (publish) begin
        win <= win + 16'd1;
        if (load) begin
          o_count    <= cnt;
          o_overflow <= ovf;
          o_window   <= win;
        end else if (o_drops != '1) begin
          o_drops <= o_drops + 16'd1;
        end
      end
      // A load in the same cycle as a transfer keeps valid high with the new payload
      if (load)         o_valid <= 1'b1;
      else if (i_ready) o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gated_event_counter.sv
// Directed and randomized windows for gated_event_counter, checked against a
// window-level model (events per window, held result, drops, running total).
module tb_gated_event_counter;

  localparam int unsigned CW   = 4;
  localparam int unsigned TW   = 32;
  localparam int          MAXC = 15;

  logic          i_clk = 1'b0;
  logic          i_rst, i_gate, i_event, i_ready;
  logic          o_valid;
  logic [CW-1:0] o_count;
  logic [15:0]   o_window;
  logic          o_overflow;
  logic [15:0]   o_drops;
  logic [TW-1:0] o_total;
  logic          o_busy;

  int total = 0;
  int bad   = 0;

  bit          m_valid;
  int          m_count;
  bit          m_ovf;
  int          m_window;
  int          m_win;
  int          m_drops;
  int unsigned m_total;

  gated_event_counter #(.COUNT_W(CW), .TOTAL_W(TW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_gate(i_gate), .i_event(i_event),
    .i_ready(i_ready), .o_valid(o_valid), .o_count(o_count),
    .o_window(o_window), .o_overflow(o_overflow), .o_drops(o_drops),
    .o_total(o_total), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset;
    m_valid  = 0;
    m_count  = 0;
    m_ovf    = 0;
    m_window = 0;
    m_win    = 0;
    m_drops  = 0;
    m_total  = 0;
  endtask

  task automatic model_close(input int n, input bit rdy);
    if (!m_valid || rdy) begin
      m_valid  = 1;
      m_count  = (n > MAXC) ? MAXC : n;
      m_ovf    = (n > MAXC);
      m_window = m_win;
    end else if (m_drops < 65535) begin
      m_drops++;
    end
    m_win   = (m_win + 1) % 65536;
    m_total = m_total + n;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, o_valid, m_valid);
    if (m_valid) begin
      check({tag, ".count"}, o_count, m_count);
      check({tag, ".window"}, o_window, m_window);
      check({tag, ".ovf"}, o_overflow, m_ovf);
    end
    check({tag, ".drops"}, o_drops, m_drops);
    check({tag, ".total"}, o_total, m_total);
  endtask

  task automatic reset_check(input string tag);
    check({tag, ".valid"}, o_valid, 0);
    check({tag, ".count"}, o_count, 0);
    check({tag, ".window"}, o_window, 0);
    check({tag, ".ovf"}, o_overflow, 0);
    check({tag, ".drops"}, o_drops, 0);
    check({tag, ".total"}, o_total, 0);
    check({tag, ".busy"}, o_busy, 0);
  endtask

  task automatic do_reset(input string tag);
    i_rst   = 1;
    i_gate  = 0;
    i_event = 0;
    tick;
    tick;
    i_rst = 0;
    model_reset;
    reset_check(tag);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      i_event = 1;
      tick;
      i_event = 0;
      tick;
    end
  endtask

  // Events are issued well inside the window, so all n are counted
  task automatic open_window(input int n);
    i_gate = 1;
    tick;
    pulses(n);
    repeat (3) tick;
    i_gate = 0;
  endtask

  // Called right after the gate drops: fall-detect cycle, then DONE, then result
  task automatic drain(input int n, input bit late_ready, input string tag);
    tick;
    check({tag, ".busy_done"}, o_busy, 1);
    check({tag, ".valid_early"}, o_valid, m_valid);
    if (late_ready) i_ready = 1;
    tick;
    model_close(n, i_ready);
    check_all(tag);
    check({tag, ".busy_idle"}, o_busy, 0);
    if (i_ready && m_valid) begin
      tick;
      m_valid = 0;
      check({tag, ".valid_taken"}, o_valid, 0);
    end
  endtask

  initial begin
    int n;
    bit rdy;
    i_ready = 0;
    do_reset("reset");

    // Isolated window
    i_ready = 1;
    open_window(3);
    drain(3, 0, "isolated");

    // Event coincident with rise counts; event coincident with fall does not
    i_event = 1;
    tick;
    i_event = 0;
    tick;
    i_gate = 1;
    tick;
    pulses(2);
    repeat (3) tick;
    i_event = 1;
    tick;
    i_event = 0;
    tick;
    i_gate = 0;
    drain(3, 0, "edges");

    // Saturation of the 4-bit window count
    open_window(20);
    drain(20, 0, "sat");

    // One-cycle gate
    i_gate = 1;
    tick;
    i_gate = 0;
    drain(0, 0, "gate1");

    // Overrun from a fresh start
    do_reset("reset2");
    i_ready = 0;
    open_window(1);
    drain(1, 0, "ovr0");
    open_window(2);
    drain(2, 0, "ovr1");
    open_window(3);
    drain(3, 0, "ovr2");
    i_ready = 1;
    tick;
    m_valid = 0;
    check("ovr.valid_taken", o_valid, 0);
    check("ovr.drops_kept", o_drops, m_drops);

    // Transfer and new load in the same DONE cycle
    i_ready = 0;
    open_window(1);
    drain(1, 0, "hold");
    open_window(4);
    drain(4, 1, "swap");

    // Back-to-back windows, gate low a single cycle
    i_ready = 1;
    i_gate  = 1;
    tick;
    pulses(2);
    repeat (3) tick;
    i_gate = 0;
    tick;
    i_gate = 1;
    tick;
    model_close(2, 1);
    check_all("b2b0");
    check("b2b0.busy", o_busy, 1);
    tick;
    m_valid = 0;
    check("b2b0.valid_taken", o_valid, 0);
    pulses(5);
    repeat (3) tick;
    i_gate = 0;
    drain(5, 0, "b2b1");

    // Reset in the middle of an open window
    i_gate = 1;
    tick;
    pulses(4);
    i_rst  = 1;
    i_gate = 0;
    tick;
    tick;
    i_rst = 0;
    model_reset;
    reset_check("midrst");
    open_window(2);
    drain(2, 0, "post_rst");

    // Randomized windows, event counts and readout readiness
    for (int w = 0; w < 12; w++) begin
      n   = int'($urandom_range(0, 12));
      rdy = 1'($urandom % 2);
      i_ready = rdy;
      tick;
      if (rdy) m_valid = 0;
      repeat ($urandom_range(0, 2)) tick;
      open_window(n);
      drain(n, 0, "rnd");
      if (!rdy && m_valid && ($urandom % 2 == 1)) begin
        i_ready = 1;
        tick;
        m_valid = 0;
        check("rnd.valid_taken", o_valid, 0);
        i_ready = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
